// File: rtl/invaders_formation.sv
// Alien formation: alive mask, descent count, sideways march with edge bounce
// Ports: clk_36MHz/reset (sync, low), frame_tick, gameplay, hit_valid/hit_index
//        -> invaders_array, invaders_line, invaders_x, direction, step_pulse
module invaders_formation #(
  parameter int X_START        = 88,
  parameter int X_MIN          = 0,
  parameter int X_MAX          = 800,
  parameter int COL_PITCH      = 64,
  parameter int INV_WIDTH      = 48,
  parameter int STEP_X         = 8,
  parameter int MIN_PERIOD     = 2,
  parameter int PERIOD_PER_INV = 1
) (
  input  logic        clk_36MHz,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [1:0]  gameplay,
  input  logic        hit_valid,
  input  logic [4:0]  hit_index,
  output logic [19:0] invaders_array,
  output logic [3:0]  invaders_line,
  output logic [9:0]  invaders_x,
  output logic        direction,
  output logic        step_pulse
);

  typedef enum logic {
    RUN,
    FROZEN
  } mode_t;

  mode_t       mode;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic [19:0] array_d;
  logic [3:0]  line_d;
  logic [9:0]  x_d;
  logic        dir_d;
  logic        step;

  logic [4:0]  alive;
  logic [7:0]  period;
  logic [9:0]  cols;
  logic [3:0]  lc;
  logic [3:0]  rc;
  logic [10:0] left_edge;
  logic [10:0] right_edge;
  logic [3:0]  line_inc;

  // Run/frozen is decided from the live inputs and the registered mask,
  // so clearing the last invader freezes the formation on the next cycle.
  always_comb begin
    mode = FROZEN;
    if (gameplay == 2'b00 && invaders_array != 20'd0)
      mode = RUN;
  end

  // Geometry and period, all from the registered (pre-hit) mask.
  always_comb begin
    alive = 5'd0;
    for (int i = 0; i < 20; i++)
      alive = alive + 5'(invaders_array[i]);
    for (int c = 0; c < 10; c++)
      cols[c] = invaders_array[c] | invaders_array[c+10];
    lc = 4'd0;
    for (int c = 9; c >= 0; c--)
      if (cols[c]) lc = 4'(c);
    rc = 4'd0;
    for (int c = 0; c < 10; c++)
      if (cols[c]) rc = 4'(c);
    period = 8'(MIN_PERIOD)
           + 8'(PERIOD_PER_INV) * {3'b000, alive};
    left_edge  = {1'b0, invaders_x}
               + 11'(lc) * 11'(COL_PITCH);
    right_edge = {1'b0, invaders_x}
               + 11'(rc) * 11'(COL_PITCH)
               + 11'(INV_WIDTH);
    line_inc = (invaders_line == 4'd15)
             ? 4'd15 : invaders_line + 4'd1;
  end

  always_comb begin
    cnt_d   = cnt_q;
    array_d = invaders_array;
    line_d  = invaders_line;
    x_d     = invaders_x;
    dir_d   = direction;
    step    = 1'b0;
    unique case (mode)
      RUN: begin
        if (hit_valid && hit_index < 5'd20)
          array_d[hit_index] = 1'b0;
        if (frame_tick) begin
          if (cnt_q + 8'd1 >= period) begin
            cnt_d = 8'd0;
            step  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        if (step) begin
          if (!direction) begin
            if (right_edge + 11'(STEP_X) > 11'(X_MAX)) begin
              line_d = line_inc;
              dir_d  = 1'b1;
            end else begin
              x_d = invaders_x + 10'(STEP_X);
            end
          end else begin
            if (left_edge < 11'(X_MIN + STEP_X)) begin
              line_d = line_inc;
              dir_d  = 1'b0;
            end else begin
              x_d = invaders_x - 10'(STEP_X);
            end
          end
        end
      end
      FROZEN: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_36MHz) begin
    if (!reset) begin
      invaders_array <= 20'hFFFFF;
      invaders_line  <= 4'd0;
      invaders_x     <= 10'(X_START);
      direction      <= 1'b0;
      step_pulse     <= 1'b0;
      cnt_q          <= 8'd0;
    end else begin
      invaders_array <= array_d;
      invaders_line  <= line_d;
      invaders_x     <= x_d;
      direction      <= dir_d;
      step_pulse     <= step;
      cnt_q          <= cnt_d;
    end
  end

endmodule

// File: tb/tb_invaders_formation.sv
// Bench for invaders_formation: step events checked against a queue of
// expected x/line/direction; static state checked inline per scenario.
module tb_invaders_formation;

  logic        clk_36MHz = 1'b0;
  logic        reset = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  gameplay = 2'b00;
  logic        hit_valid = 1'b0;
  logic [4:0]  hit_index = 5'd0;
  logic [19:0] invaders_array;
  logic [3:0]  invaders_line;
  logic [9:0]  invaders_x;
  logic        direction;
  logic        step_pulse;

  typedef struct packed {
    logic [9:0] x;
    logic [3:0] line;
    logic       dir;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int pulses = 0;

  invaders_formation dut (
    .clk_36MHz(clk_36MHz),
    .reset(reset),
    .frame_tick(frame_tick),
    .gameplay(gameplay),
    .hit_valid(hit_valid),
    .hit_index(hit_index),
    .invaders_array(invaders_array),
    .invaders_line(invaders_line),
    .invaders_x(invaders_x),
    .direction(direction),
    .step_pulse(step_pulse)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  always @(negedge clk_36MHz) begin
    if (step_pulse === 1'b1) begin
      exp_t e;
      pulses++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL step_unexpected: x=%0d line=%0d dir=%0d, no step expected",
                 invaders_x, invaders_line, direction);
      end else begin
        e = sb.pop_front();
        if ({invaders_x, invaders_line, direction} !== e) begin
          bad++;
          $display("FAIL step_state: got x=%0d line=%0d dir=%0d want x=%0d line=%0d dir=%0d",
                   invaders_x, invaders_line, direction,
                   e.x, e.line, e.dir);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_36MHz);
    reset = 1'b0;
    frame_tick = 1'b0;
    hit_valid = 1'b0;
    gameplay = 2'b00;
    @(negedge clk_36MHz);
    @(negedge clk_36MHz);
    reset = 1'b1;
    sb.delete();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_36MHz);
      frame_tick = 1'b1;
      @(negedge clk_36MHz);
      frame_tick = 1'b0;
    end
    @(negedge clk_36MHz);
  endtask

  task automatic hit(input logic [4:0] idx);
    @(negedge clk_36MHz);
    hit_valid = 1'b1;
    hit_index = idx;
    @(negedge clk_36MHz);
    hit_valid = 1'b0;
    @(negedge clk_36MHz);
  endtask

  task automatic push(input int x, input int line, input logic dir);
    exp_t e;
    e.x = 10'(x);
    e.line = 4'(line);
    e.dir = dir;
    sb.push_back(e);
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected steps never seen, want 0",
               name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({invaders_array, invaders_line, invaders_x, direction, step_pulse}
        !== {20'hFFFFF, 4'd0, 10'd88, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got arr=%h line=%0d x=%0d dir=%0d sp=%0d want FFFFF/0/88/0/0",
               invaders_array, invaders_line, invaders_x,
               direction, step_pulse);
    end
  endtask

  task automatic test_period();
    int p0;
    do_reset();
    p0 = pulses;
    ticks(21);
    total++;
    if (invaders_x !== 10'd88 || pulses != p0) begin
      bad++;
      $display("FAIL period_21: got x=%0d pulses=%0d want x=88 pulses=0",
               invaders_x, pulses - p0);
    end
    push(96, 0, 1'b0);
    ticks(1);
    total++;
    if (invaders_x !== 10'd96 || pulses != p0 + 1) begin
      bad++;
      $display("FAIL period_22: got x=%0d pulses=%0d want x=96 pulses=1",
               invaders_x, pulses - p0);
    end
    check_drained("period");
  endtask

  task automatic test_march_bounce();
    do_reset();
    for (int k = 1; k <= 11; k++)
      push(88 + 8 * k, 0, 1'b0);
    push(176, 1, 1'b1);
    push(168, 1, 1'b1);
    ticks(13 * 22);
    total++;
    if ({invaders_x, invaders_line, direction} !== {10'd168, 4'd1, 1'b1}) begin
      bad++;
      $display("FAIL bounce_right: got x=%0d line=%0d dir=%0d want 168/1/1",
               invaders_x, invaders_line, direction);
    end
    check_drained("bounce");
  endtask

  task automatic test_column_kill();
    do_reset();
    hit(5'd9);
    hit(5'd19);
    total++;
    if (invaders_array !== 20'h7FDFF) begin
      bad++;
      $display("FAIL col_kill_arr: got %h want 7fdff", invaders_array);
    end
    for (int k = 1; k <= 19; k++)
      push(88 + 8 * k, 0, 1'b0);
    push(240, 1, 1'b1);
    ticks(20 * 20);
    total++;
    if ({invaders_x, invaders_line, direction} !== {10'd240, 4'd1, 1'b1}) begin
      bad++;
      $display("FAIL col_kill_bounce: got x=%0d line=%0d dir=%0d want 240/1/1",
               invaders_x, invaders_line, direction);
    end
    check_drained("col_kill");
  endtask

  task automatic test_ignored_hits();
    int p0;
    do_reset();
    hit(5'd3);
    total++;
    if (invaders_array !== 20'hFFFF7) begin
      bad++;
      $display("FAIL hit3: got %h want ffff7", invaders_array);
    end
    hit(5'd3);
    hit(5'd25);
    total++;
    if (invaders_array !== 20'hFFFF7) begin
      bad++;
      $display("FAIL hit_noop: got %h want ffff7", invaders_array);
    end
    @(negedge clk_36MHz);
    gameplay = 2'b10;
    p0 = pulses;
    ticks(40);
    hit(5'd0);
    total++;
    if (invaders_x !== 10'd88 || pulses != p0
        || invaders_array !== 20'hFFFF7) begin
      bad++;
      $display("FAIL frozen: got x=%0d pulses=%0d arr=%h want 88/0/ffff7",
               invaders_x, pulses - p0, invaders_array);
    end
  endtask

  task automatic test_kill_all_and_reset();
    int p0;
    do_reset();
    for (int i = 0; i < 20; i++)
      hit(5'(i));
    total++;
    if (invaders_array !== 20'd0) begin
      bad++;
      $display("FAIL kill_all: got %h want 00000", invaders_array);
    end
    p0 = pulses;
    ticks(100);
    total++;
    if (pulses != p0 || invaders_x !== 10'd88) begin
      bad++;
      $display("FAIL empty_frozen: got pulses=%0d x=%0d want 0/88",
               pulses - p0, invaders_x);
    end
    do_reset();
    ticks(15);
    do_reset();
    ticks(21);
    total++;
    if (invaders_x !== 10'd88) begin
      bad++;
      $display("FAIL reset_mid: got x=%0d want 88", invaders_x);
    end
    push(96, 0, 1'b0);
    ticks(1);
    total++;
    if (invaders_x !== 10'd96) begin
      bad++;
      $display("FAIL reset_first_step: got x=%0d want 96", invaders_x);
    end
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_period();
    test_march_bounce();
    test_column_kill();
    test_ignored_hits();
    test_kill_all_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
